// File: rtl/frame_read_client.sv
// frame_read_client: read-side client of BufferController. On frame_start it
// requests a readable buffer, latches the granted id, fetches the frame from
// SDRAM in fixed bursts, streams the words to the pixel FIFO and releases the
// buffer with finalize_rd.
// Ports:
//   clk, reset_n                  fb_clk domain clock, async active-low reset
//   frame_start                   display asks for the next frame
//   read_rq_rdy, finalize_rd      buffer request / release to BufferController
//   buffer_id_valid, buffer_id    grant strobe and granted index
//   mem_busy, mem_rd_req/addr     SDRAM burst request side
//   mem_rd_valid, mem_rd_data     SDRAM returned beats
//   fifo_afull                    pixel FIFO cannot take a full burst
//   pix_valid/data/sof/eof        pixel stream (no backpressure)
//   frame_done, frame_overrun,    status pulses
//   id_error
module frame_read_client #(
    parameter int FRAME_WORDS = 76800,
    parameter int BURST_LEN   = 32,
    parameter int BUF_STRIDE  = 131072,
    parameter int ADDR_W      = 21,
    parameter int DATA_W      = 16,
    // 3 = SVL_VERBOSE_INFO
    parameter int LOG_LEVEL   = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_start,
    output logic              read_rq_rdy,
    output logic              finalize_rd,
    input  logic              buffer_id_valid,
    input  logic [1:0]        buffer_id,
    input  logic              mem_busy,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              fifo_afull,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_sof,
    output logic              pix_eof,
    output logic              frame_done,
    output logic              frame_overrun,
    output logic              id_error
);

    localparam int WC_W = $clog2(FRAME_WORDS + 1);
    localparam int BC_W = $clog2(BURST_LEN + 1);

    if ((FRAME_WORDS % BURST_LEN) != 0) begin : g_len_chk
        $error("FRAME_WORDS must be a multiple of BURST_LEN");
    end

    if (LOG_LEVEL < 0) begin : g_log_chk
        $error("LOG_LEVEL must be non-negative");
    end

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ISSUE,
        WAIT,
        FIN
    } state_t;

    state_t state;
    state_t next_state;

    logic [1:0]      id_q;
    logic [WC_W-1:0] word_cnt;
    logic [BC_W-1:0] beat_cnt;
    logic [WC_W-1:0] pix_idx;
    logic            beat_in;
    logic            last_beat;
    logic            frame_end;
    logic            grant;
    logic            can_issue;

    logic              read_rq_rdy_d;
    logic              finalize_rd_d;
    logic              mem_rd_req_d;
    logic [ADDR_W-1:0] mem_rd_addr_d;
    logic              pix_valid_d;
    logic [DATA_W-1:0] pix_data_d;
    logic              pix_sof_d;
    logic              pix_eof_d;
    logic              frame_overrun_d;
    logic              id_error_d;

    assign pix_idx   = word_cnt + WC_W'(beat_cnt);
    assign beat_in   = (state == WAIT) && mem_rd_valid;
    assign last_beat = beat_in && (beat_cnt == BC_W'(BURST_LEN - 1));
    assign frame_end = (word_cnt + WC_W'(BURST_LEN)) == WC_W'(FRAME_WORDS);
    assign grant     = (state == REQ) && buffer_id_valid;
    assign can_issue = !mem_busy && !fifo_afull;

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            read_rq_rdy   <= 1'b0;
            finalize_rd   <= 1'b0;
            mem_rd_req    <= 1'b0;
            mem_rd_addr   <= '0;
            pix_valid     <= 1'b0;
            pix_data      <= '0;
            pix_sof       <= 1'b0;
            pix_eof       <= 1'b0;
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;
            id_error      <= 1'b0;
        end else begin
            state         <= next_state;
            read_rq_rdy   <= read_rq_rdy_d;
            finalize_rd   <= finalize_rd_d;
            mem_rd_req    <= mem_rd_req_d;
            mem_rd_addr   <= mem_rd_addr_d;
            pix_valid     <= pix_valid_d;
            pix_data      <= pix_data_d;
            pix_sof       <= pix_sof_d;
            pix_eof       <= pix_eof_d;
            frame_done    <= finalize_rd_d;
            frame_overrun <= frame_overrun_d;
            id_error      <= id_error_d;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (frame_start) next_state = REQ;
            end
            REQ: begin
                if (buffer_id_valid) begin
                    next_state = (buffer_id == 2'd3) ? IDLE : ISSUE;
                end
            end
            ISSUE: begin
                if (can_issue) next_state = WAIT;
            end
            WAIT: begin
                if (last_beat) next_state = frame_end ? FIN : ISSUE;
            end
            FIN: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        read_rq_rdy_d   = (next_state == REQ);
        finalize_rd_d   = (state == WAIT) && (next_state == FIN);
        mem_rd_req_d    = (state == ISSUE) && can_issue;
        mem_rd_addr_d   = mem_rd_addr;
        pix_valid_d     = beat_in;
        pix_data_d      = pix_data;
        pix_sof_d       = beat_in && (pix_idx == '0);
        pix_eof_d       = beat_in && (pix_idx == WC_W'(FRAME_WORDS - 1));
        frame_overrun_d = frame_start && (state != IDLE);
        id_error_d      = grant && (buffer_id == 2'd3);
        if (mem_rd_req_d) begin
            mem_rd_addr_d = ADDR_W'(id_q) * ADDR_W'(BUF_STRIDE)
                          + ADDR_W'(word_cnt);
        end
        if (beat_in) begin
            pix_data_d = mem_rd_data;
        end
    end

    // Buffer id and frame/burst position
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_q     <= '0;
            word_cnt <= '0;
            beat_cnt <= '0;
        end else if (grant) begin
            id_q     <= buffer_id;
            word_cnt <= '0;
            beat_cnt <= '0;
        end else if (last_beat) begin
            beat_cnt <= '0;
            word_cnt <= word_cnt + WC_W'(BURST_LEN);
        end else if (beat_in) begin
            beat_cnt <= beat_cnt + BC_W'(1);
        end
    end

endmodule

// File: tb/tb_frame_read_client.sv
// tb_frame_read_client: directed bench for frame_read_client with a small
// SDRAM responder and an output monitor.
module tb_frame_read_client;

    localparam int FW = 64;
    localparam int BL = 32;
    localparam int BS = 128;
    localparam int AW = 21;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          frame_start = 1'b0;
    logic          read_rq_rdy;
    logic          finalize_rd;
    logic          buffer_id_valid = 1'b0;
    logic [1:0]    buffer_id = 2'd0;
    logic          mem_busy = 1'b0;
    logic          mem_rd_req;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_rd_valid = 1'b0;
    logic [DW-1:0] mem_rd_data = '0;
    logic          fifo_afull = 1'b0;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic          pix_sof;
    logic          pix_eof;
    logic          frame_done;
    logic          frame_overrun;
    logic          id_error;

    int errors = 0;
    int checks = 0;

    int pix_n = 0;
    int sof_at = 0;
    int eof_at = -1;
    int data_bad = 0;
    int fin_n = 0;
    int done_n = 0;
    int ovr_n = 0;
    int req_n = 0;
    int rq_n = 0;
    int both_bad = 0;
    int exp_base = 0;
    logic [AW-1:0] addr_q[$];

    wire [45:0] all_out = {read_rq_rdy, finalize_rd, mem_rd_req,
                           mem_rd_addr, pix_valid, pix_data, pix_sof,
                           pix_eof, frame_done, frame_overrun, id_error};

    frame_read_client #(
        .FRAME_WORDS(FW),
        .BURST_LEN  (BL),
        .BUF_STRIDE (BS),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .LOG_LEVEL  (3)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .frame_start    (frame_start),
        .read_rq_rdy    (read_rq_rdy),
        .finalize_rd    (finalize_rd),
        .buffer_id_valid(buffer_id_valid),
        .buffer_id      (buffer_id),
        .mem_busy       (mem_busy),
        .mem_rd_req     (mem_rd_req),
        .mem_rd_addr    (mem_rd_addr),
        .mem_rd_valid   (mem_rd_valid),
        .mem_rd_data    (mem_rd_data),
        .fifo_afull     (fifo_afull),
        .pix_valid      (pix_valid),
        .pix_data       (pix_data),
        .pix_sof        (pix_sof),
        .pix_eof        (pix_eof),
        .frame_done     (frame_done),
        .frame_overrun  (frame_overrun),
        .id_error       (id_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (pix_valid) begin
            if (pix_sof) sof_at = pix_n;
            if (pix_eof) eof_at = pix_n;
            if (pix_data !== 16'(exp_base + (pix_n - sof_at))) data_bad++;
            pix_n++;
        end
        if (mem_rd_req) begin
            req_n++;
            addr_q.push_back(mem_rd_addr);
        end
        if (finalize_rd) fin_n++;
        if (frame_done) done_n++;
        if (frame_overrun) ovr_n++;
        if (read_rq_rdy) rq_n++;
        if (read_rq_rdy && finalize_rd) both_bad++;
    end

    // SDRAM responder: one cycle latency, data = low address bits + beat
    initial begin
        logic [AW-1:0] a;
        forever begin
            tick();
            if (mem_rd_req && reset_n) begin
                a = mem_rd_addr;
                tick();
                for (int i = 0; i < BL; i++) begin
                    if (!reset_n) break;
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = a[DW-1:0] + 16'(i);
                    tick();
                end
                mem_rd_valid = 1'b0;
            end
        end
    end

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic grant(input logic [1:0] id, input int delay);
        repeat (delay) tick();
        buffer_id       = id;
        buffer_id_valid = 1'b1;
        tick();
        buffer_id_valid = 1'b0;
    endtask

    task automatic wait_fin(output bit ok);
        int f0;
        f0 = fin_n;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (fin_n != f0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", all_out);
        end
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL idle_outputs got=%h want=0", all_out);
        end
    endtask

    task automatic test_frames();
        int ids[3] = '{1, 2, 0};
        for (int k = 0; k < 3; k++) begin
            int p0, a0, f0, d0, dn0;
            logic [AW-1:0] g0, g1;
            bit ok;
            p0 = pix_n; a0 = addr_q.size(); f0 = fin_n;
            d0 = data_bad; dn0 = done_n;
            exp_base = ids[k] * BS;
            pulse_start();
            grant(2'(ids[k]), 0);
            wait_fin(ok);
            tick();
            g0 = (addr_q.size() > a0) ? addr_q[a0] : 'x;
            g1 = (addr_q.size() > a0 + 1) ? addr_q[a0 + 1] : 'x;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL frame%0d_done got=timeout want=finalize", k);
            end
            checks++;
            if (addr_q.size() - a0 != 2) begin
                errors++;
                $display("FAIL frame%0d_reqs got=%0d want=2", k,
                         addr_q.size() - a0);
            end
            checks++;
            if (g0 !== AW'(ids[k] * BS)) begin
                errors++;
                $display("FAIL frame%0d_addr0 got=%0d want=%0d", k, g0,
                         ids[k] * BS);
            end
            checks++;
            if (g1 !== AW'(ids[k] * BS + 32)) begin
                errors++;
                $display("FAIL frame%0d_addr1 got=%0d want=%0d", k, g1,
                         ids[k] * BS + 32);
            end
            checks++;
            if (pix_n - p0 != FW) begin
                errors++;
                $display("FAIL frame%0d_pixels got=%0d want=%0d", k,
                         pix_n - p0, FW);
            end
            checks++;
            if (sof_at != p0 || eof_at - p0 != FW - 1) begin
                errors++;
                $display("FAIL frame%0d_sof_eof got=%0d/%0d want=0/%0d", k,
                         sof_at - p0, eof_at - p0, FW - 1);
            end
            checks++;
            if (data_bad != d0) begin
                errors++;
                $display("FAIL frame%0d_data got=%0d want=0 bad words", k,
                         data_bad - d0);
            end
            checks++;
            if (fin_n - f0 != 1 || done_n - dn0 != 1) begin
                errors++;
                $display("FAIL frame%0d_finalize got=%0d/%0d want=1/1", k,
                         fin_n - f0, done_n - dn0);
            end
        end
    endtask

    task automatic test_grant_delay();
        int hi, r0, f0;
        bit ok;
        exp_base = 2 * BS;
        r0 = req_n; f0 = fin_n; hi = 0;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            if (read_rq_rdy === 1'b1) hi++;
            tick();
        end
        buffer_id = 2'd2;
        buffer_id_valid = 1'b1;
        checks++;
        if (hi != 5) begin
            errors++;
            $display("FAIL grant_delay_rq got=%0d want=5 cycles", hi);
        end
        checks++;
        if (req_n != r0) begin
            errors++;
            $display("FAIL grant_delay_noreq got=%0d want=0", req_n - r0);
        end
        tick();
        buffer_id_valid = 1'b0;
        checks++;
        if (read_rq_rdy !== 1'b0) begin
            errors++;
            $display("FAIL grant_delay_rq_drop got=%b want=0", read_rq_rdy);
        end
        wait_fin(ok);
        checks++;
        if (!ok || fin_n - f0 != 1) begin
            errors++;
            $display("FAIL grant_delay_fin got=%0d want=1", fin_n - f0);
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 2; c++) begin
            int r0;
            bit ok;
            exp_base = BS;
            if (c == 0) fifo_afull = 1'b1;
            else mem_busy = 1'b1;
            pulse_start();
            grant(2'd1, 0);
            r0 = req_n;
            repeat (10) tick();
            fifo_afull = 1'b0;
            mem_busy = 1'b0;
            checks++;
            if (req_n != r0 || mem_rd_req !== 1'b0) begin
                errors++;
                $display("FAIL stall%0d_noreq got=%0d want=0", c, req_n - r0);
            end
            tick();
            checks++;
            if (mem_rd_req !== 1'b1 || mem_rd_addr !== AW'(BS)) begin
                errors++;
                $display("FAIL stall%0d_release got=%b@%0d want=1@%0d", c,
                         mem_rd_req, mem_rd_addr, BS);
            end
            wait_fin(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL stall%0d_fin got=timeout want=finalize", c);
            end
        end
    endtask

    task automatic test_overrun();
        int o0, r0;
        bit seen;
        exp_base = BS;
        pulse_start();
        grant(2'd1, 0);
        o0 = ovr_n;
        repeat (20) tick();
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (finalize_rd === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (seen) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
        end
        r0 = rq_n;
        repeat (6) tick();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL overrun_fin got=timeout want=finalize");
        end
        checks++;
        if (ovr_n - o0 != 2) begin
            errors++;
            $display("FAIL overrun_count got=%0d want=2", ovr_n - o0);
        end
        checks++;
        if (rq_n != r0) begin
            errors++;
            $display("FAIL overrun_no_req got=%0d want=0", rq_n - r0);
        end
    endtask

    task automatic test_bad_id();
        int r0, f0;
        bit ok;
        pulse_start();
        r0 = req_n; f0 = fin_n;
        buffer_id = 2'd3;
        buffer_id_valid = 1'b1;
        tick();
        buffer_id_valid = 1'b0;
        checks++;
        if (id_error !== 1'b1) begin
            errors++;
            $display("FAIL bad_id_pulse got=%b want=1", id_error);
        end
        tick();
        checks++;
        if (id_error !== 1'b0) begin
            errors++;
            $display("FAIL bad_id_width got=%b want=0", id_error);
        end
        repeat (10) tick();
        checks++;
        if (req_n != r0 || fin_n != f0 || read_rq_rdy !== 1'b0) begin
            errors++;
            $display("FAIL bad_id_quiet got=req%0d/fin%0d/rq%b want=0/0/0",
                     req_n - r0, fin_n - f0, read_rq_rdy);
        end
        exp_base = 2 * BS;
        pulse_start();
        checks++;
        if (read_rq_rdy !== 1'b1 || frame_overrun !== 1'b0) begin
            errors++;
            $display("FAIL bad_id_idle got=rq%b/ovr%b want=1/0",
                     read_rq_rdy, frame_overrun);
        end
        grant(2'd2, 0);
        wait_fin(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bad_id_next got=timeout want=finalize");
        end
    endtask

    task automatic test_reset_midframe();
        int p0, f0, p1, a1;
        logic [AW-1:0] g0;
        bit hit, ok;
        exp_base = 2 * BS;
        pulse_start();
        grant(2'd2, 0);
        p0 = pix_n; f0 = fin_n;
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (pix_n - p0 >= 40) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (!hit || all_out !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got=%h want=0", all_out);
        end
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (60) tick();
        checks++;
        if (fin_n != f0) begin
            errors++;
            $display("FAIL midreset_no_fin got=%0d want=0", fin_n - f0);
        end
        p1 = pix_n; a1 = addr_q.size();
        exp_base = BS;
        pulse_start();
        grant(2'd1, 0);
        wait_fin(ok);
        g0 = (addr_q.size() > a1) ? addr_q[a1] : 'x;
        checks++;
        if (!ok || g0 !== AW'(BS)) begin
            errors++;
            $display("FAIL midreset_restart_addr got=%0d want=%0d", g0, BS);
        end
        checks++;
        if (pix_n - p1 != FW || sof_at != p1 || eof_at - p1 != FW - 1) begin
            errors++;
            $display("FAIL midreset_restart_frame got=%0d/%0d/%0d want=%0d/0/%0d",
                     pix_n - p1, sof_at - p1, eof_at - p1, FW, FW - 1);
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_grant_delay();
        test_backpressure();
        test_overrun();
        test_bad_id();
        test_reset_midframe();
        checks++;
        if (data_bad != 0) begin
            errors++;
            $display("FAIL pixel_data got=%0d want=0 bad words", data_bad);
        end
        checks++;
        if (both_bad != 0) begin
            errors++;
            $display("FAIL rq_fin_overlap got=%0d want=0", both_bad);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
